i2s_audio_tx: RTL

//  Serialises guest stereo PCM into a standard I2S stream on I2S_BCK/I2S_LRCK/I2S_DATA.

---
 rtl/i2s_audio_tx_if.sv | 32 +++
 rtl/i2s_audio_tx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/i2s_audio_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_audio_tx_if
//  Description : Sample handshake and I2S pin bundle for i2s_audio_tx.
//                The master side supplies stereo samples and observes the
//                serial stream; the slave side is the transmitter itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface i2s_audio_tx_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] l_in;
    logic [DATA_W-1:0] r_in;
    logic              in_valid;
    logic              in_ready;
    logic              sample_req;
    logic              underrun;
    logic              i2s_bck;
    logic              i2s_lrck;
    logic              i2s_data;

    modport master (
        output l_in, r_in, in_valid,
        input  in_ready, sample_req, underrun, i2s_bck, i2s_lrck, i2s_data
    );

    modport slave (
        input  l_in, r_in, in_valid,
        output in_ready, sample_req, underrun, i2s_bck, i2s_lrck, i2s_data
    );
endinterface
`default_nettype wire

// File: rtl/i2s_audio_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_audio_tx
//  Description : I2S master transmitter. Generates BCK/LRCK from clk and
//                serialises one stereo frame (left then right, MSB first)
//                per LRCK period. A single-entry holding register with a
//                valid/ready handshake decouples the source sample rate;
//                when no new sample is waiting at a frame boundary the last
//                frame is repeated and underrun pulses.
//  Options     : define I2S_UNSIGNED_CONV_EN to invert the sample MSBs on
//                accept (offset-binary input -> two's complement output).
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_audio_tx #(
    parameter int DATA_W   = 16,
    parameter int BCK_HALF = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    i2s_audio_tx_if.slave      bus
);

    localparam int c_FRAME_W = 2 * DATA_W;
    localparam int c_BIT_W   = $clog2(c_FRAME_W);
    localparam int c_DIV_W   = $clog2(BCK_HALF);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCK_HALF - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_FRAME_W - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
    // LRCK is high for the right slot shifted one BCK early
    localparam logic [c_BIT_W-1:0] c_LRCK_LO  = c_BIT_W'(DATA_W - 1);
    localparam logic [c_BIT_W-1:0] c_LRCK_HI  = c_BIT_W'(c_FRAME_W - 2);

    logic [c_DIV_W-1:0]   r_div_cnt;
    logic                 r_bck;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [c_FRAME_W-1:0] r_shift;
    logic                 r_data;
    logic                 r_lrck;
    logic [c_FRAME_W-1:0] r_pend;
    logic [c_FRAME_W-1:0] r_last;
    logic                 r_pend_full;
    logic                 r_sample_req;
    logic                 r_underrun;

    logic                 w_tick;
    logic                 w_fall;
    logic                 w_load;
    logic                 w_accept;
    logic [c_BIT_W-1:0]   w_bit_nxt;
    logic [c_FRAME_W-1:0] w_shift_nxt;
    logic                 w_lrck_nxt;
    logic [DATA_W-1:0]    w_l_acc;
    logic [DATA_W-1:0]    w_r_acc;

    assign w_tick   = (r_div_cnt == c_DIV_LAST);
    assign w_fall   = w_tick & r_bck;
    assign w_load   = w_fall & (r_bit_cnt == c_BIT_LAST);
    assign w_accept = bus.in_valid & ~r_pend_full;

    assign w_bit_nxt   = w_load ? '0 : (r_bit_cnt + c_BIT_ONE);
    assign w_shift_nxt = w_load ? (r_pend_full ? r_pend : r_last)
                                : {r_shift[c_FRAME_W-2:0], 1'b0};
    assign w_lrck_nxt  = (w_bit_nxt >= c_LRCK_LO) && (w_bit_nxt <= c_LRCK_HI);

`ifdef I2S_UNSIGNED_CONV_EN
    assign w_l_acc = {~bus.l_in[DATA_W-1], bus.l_in[DATA_W-2:0]};
    assign w_r_acc = {~bus.r_in[DATA_W-1], bus.r_in[DATA_W-2:0]};
`else
    assign w_l_acc = bus.l_in;
    assign w_r_acc = bus.r_in;
`endif

    // Prescaler: toggle BCK every BCK_HALF clk cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_bck     <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_bck     <= ~r_bck;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_ONE;
        end
    end

    // Serialiser: advance bit position, shift data and update LRCK on BCK falls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= c_BIT_LAST;
            r_shift   <= '0;
            r_data    <= 1'b0;
            r_lrck    <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_shift_nxt[c_FRAME_W-1];
            r_lrck    <= w_lrck_nxt;
        end
    end

    // Holding register: a frame load with a pending sample consumes it;
    // otherwise an offered sample is captured while the register is empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend      <= '0;
            r_last      <= '0;
            r_pend_full <= 1'b0;
        end else if (w_load && r_pend_full) begin
            r_last      <= r_pend;
            r_pend_full <= 1'b0;
        end else if (w_accept) begin
            r_pend      <= {w_l_acc, w_r_acc};
            r_pend_full <= 1'b1;
        end
    end

    // Status pulses: one clk wide, marking each frame load and each repeat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample_req <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_sample_req <= w_load;
            r_underrun   <= w_load & ~r_pend_full;
        end
    end

    assign bus.in_ready   = ~r_pend_full;
    assign bus.sample_req = r_sample_req;
    assign bus.underrun   = r_underrun;
    assign bus.i2s_bck    = r_bck;
    assign bus.i2s_lrck   = r_lrck;
    assign bus.i2s_data   = r_data;

endmodule
`default_nettype wire
